// File: rtl/timer_ctrl_if.sv
// timer_ctrl_if: control/status bundle between a timer client and timer_ctrl
interface timer_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int PRESC_W = 3
);
  logic i_start;
  logic i_stop;
  logic i_periodic;
  logic [WIDTH-1:0] i_load;
  logic [PRESC_W-1:0] i_presc;
  logic i_irq_clr;
  logic o_busy;
  logic [WIDTH-1:0] o_count;
  logic o_tick;
  logic o_expire;
  logic o_irq;
  logic o_ovf;
  logic o_cfg_err;
  modport master (
    output i_start, i_stop, i_periodic, i_load, i_presc, i_irq_clr,
    input o_busy, o_count, o_tick, o_expire, o_irq, o_ovf, o_cfg_err
  );
  modport slave (
    input i_start, i_stop, i_periodic, i_load, i_presc, i_irq_clr,
    output o_busy, o_count, o_tick, o_expire, o_irq, o_ovf, o_cfg_err
  );
endinterface

// File: rtl/timer_ctrl.sv
// timer_ctrl: prescaled one-shot/periodic down-counting timer with sticky irq/overflow flags
module timer_ctrl #(
  parameter int WIDTH = 4,
  parameter int PRESC_W = 3
) (
  input logic clk,
  input logic rst,
  timer_ctrl_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] count, load_q;
  logic [PRESC_W-1:0] presc_cnt, presc_q;
  logic per_q, expire, irq, ovf, cfg_err;
  logic tick, start_ok, cfg_bad, exp_hit;
  assign tick = (state == RUN) && (presc_cnt == '0);
  assign bus.o_busy = (state == RUN);
  assign bus.o_tick = tick;
  assign bus.o_count = count;
  assign bus.o_expire = expire;
  assign bus.o_irq = irq;
  assign bus.o_ovf = ovf;
  assign bus.o_cfg_err = cfg_err;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  // start qualification, expiry detection (stop suppresses it) and next state
  always_comb begin
    start_ok = (state == IDLE) && bus.i_start && !bus.i_stop && (bus.i_load != '0);
    cfg_bad = (state == IDLE) && bus.i_start && !bus.i_stop && (bus.i_load == '0);
    exp_hit = tick && (count == WIDTH'(1)) && !bus.i_stop;
    state_nxt = state;
    if (state == IDLE) state_nxt = start_ok ? RUN : IDLE;
    else if (bus.i_stop || (exp_hit && !per_q)) state_nxt = IDLE;
  end
  // shadow config, prescaler, period counter and sticky flags
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      count <= '0;
      presc_cnt <= '0;
      load_q <= '0;
      presc_q <= '0;
      per_q <= 1'b0;
      expire <= 1'b0;
      irq <= 1'b0;
      ovf <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      expire <= exp_hit;
      cfg_err <= cfg_bad;
      irq <= exp_hit || (irq && !bus.i_irq_clr);
      ovf <= (exp_hit && irq && !bus.i_irq_clr) || (ovf && !bus.i_irq_clr);
      if (start_ok) begin
        load_q <= bus.i_load;
        presc_q <= bus.i_presc;
        per_q <= bus.i_periodic;
        count <= bus.i_load;
        presc_cnt <= bus.i_presc;
      end else if (state == RUN) begin
        if (bus.i_stop) begin
          count <= '0;
          presc_cnt <= '0;
        end else if (tick) begin
          presc_cnt <= presc_q;
          count <= (count == WIDTH'(1)) ? (per_q ? load_q : '0) : count - WIDTH'(1);
        end else presc_cnt <= presc_cnt - PRESC_W'(1);
      end
    end
endmodule
